// File: rtl/judge_pkg.sv
// Shared types, cell codes and the winning-line table for the board judge.
package judge_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;
  localparam logic [1:0] CELL_ILL   = 2'b11;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Rows, columns, main diagonal, anti-diagonal; the order is the scan order.
  localparam logic [3:0] LINE_CELLS [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
    return board[2*idx +: 2];
  endfunction

  // Both 00 and 11 count as empty, so a board full of illegal cells is never a draw.
  function automatic logic [3:0] count_empty(input logic [17:0] board);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_CELLS; i++)
      if (board[2*i+1] == board[2*i]) n = n + 4'd1;
    return n;
  endfunction

  function automatic logic has_illegal(input logic [17:0] board);
    logic ill;
    ill = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++)
      if (board[2*i +: 2] == CELL_ILL) ill = 1'b1;
    return ill;
  endfunction

  function automatic logic [8:0] line_mask(input logic [2:0] line);
    logic [8:0] m;
    m = '0;
    for (int j = 0; j < 3; j++) m[LINE_CELLS[line][j]] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/judge_line_eval.sv
// Ownership test of one 3-cell line.
// Latency: combinational. Backpressure: none.
module judge_line_eval
  import judge_pkg::*;
#(
  parameter logic [1:0] P1_CODE = CELL_P1,
  parameter logic [1:0] P2_CODE = CELL_P2
) (
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  output logic       own_p1,
  output logic       own_p2
);

  assign own_p1 = (cell_a == P1_CODE) && (cell_b == P1_CODE) && (cell_c == P1_CODE);
  assign own_p2 = (cell_a == P2_CODE) && (cell_b == P2_CODE) && (cell_c == P2_CODE);

endmodule

// File: rtl/board_judge.sv
// Sequential win/draw judge: snapshots the board, scans one line per cycle (optional win_mask: JUDGE_LINE_MASK_EN).
// Latency: trigger edge to done = 10 edges; one judgement per 10 cycles.
// Backpressure: start and board changes are ignored while busy, never queued.
module board_judge
  import judge_pkg::*;
#(
  parameter bit         AUTO_START = 1'b1,
  parameter logic [1:0] P1_CODE    = CELL_P1,
  parameter logic [1:0] P2_CODE    = CELL_P2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] matrix,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic [2:0]  win_line,
`ifdef JUDGE_LINE_MASK_EN
  output logic [8:0]  win_mask,
`endif
  output logic        error
);

  state_e      state;
  logic [17:0] snapshot;
  logic [2:0]  line_cnt;
  logic [3:0]  empty_cnt;
  logic        ill_seen;
  logic        own_found;
  logic        own_is_p2;
  logic [2:0]  own_idx;
  logic        err_both;
  logic        own_p1;
  logic        own_p2;
  logic        trigger;

  assign trigger = start || (AUTO_START && (matrix != snapshot));

  judge_line_eval #(
    .P1_CODE(P1_CODE),
    .P2_CODE(P2_CODE)
  ) u_line_eval (
    .cell_a(cell_at(snapshot, LINE_CELLS[line_cnt][0])),
    .cell_b(cell_at(snapshot, LINE_CELLS[line_cnt][1])),
    .cell_c(cell_at(snapshot, LINE_CELLS[line_cnt][2])),
    .own_p1(own_p1),
    .own_p2(own_p2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      snapshot  <= '0;
      line_cnt  <= '0;
      empty_cnt <= '0;
      ill_seen  <= 1'b0;
      own_found <= 1'b0;
      own_is_p2 <= 1'b0;
      own_idx   <= '0;
      err_both  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= RES_NONE;
      win_line  <= '0;
      error     <= 1'b0;
`ifdef JUDGE_LINE_MASK_EN
      win_mask  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            snapshot  <= matrix;
            busy      <= 1'b1;
            line_cnt  <= '0;
            empty_cnt <= count_empty(matrix);
            ill_seen  <= has_illegal(matrix);
            own_found <= 1'b0;
            own_is_p2 <= 1'b0;
            own_idx   <= '0;
            err_both  <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          // The first owned line wins; a later line of the other player flags a corrupt board.
          if (own_p1 || own_p2) begin
            if (!own_found) begin
              own_found <= 1'b1;
              own_is_p2 <= own_p2;
              own_idx   <= line_cnt;
            end else if (own_is_p2 != own_p2) begin
              err_both <= 1'b1;
            end
          end
          line_cnt <= line_cnt + 3'd1;
          if (line_cnt == 3'd7) state <= FINISH;
        end
        FINISH: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          win_line <= own_idx;
          error    <= ill_seen || err_both;
          if (own_found)             result <= own_is_p2 ? RES_P2 : RES_P1;
          else if (empty_cnt == 4'd0) result <= RES_DRAW;
          else                        result <= RES_NONE;
`ifdef JUDGE_LINE_MASK_EN
          win_mask <= own_found ? line_mask(own_idx) : 9'd0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_judge.sv
// Directed-vector bench for board_judge: a manual-start instance plus an auto-start instance.
module tb_board_judge;

  typedef struct {
    logic [17:0] m;
    logic [1:0]  res;
    logic [2:0]  line;
    logic        err;
    logic [8:0]  mask;
    string       tag;
  } vec_t;

  localparam logic [1:0] E = 2'b00, X = 2'b01, O = 2'b10, I = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] matrix;
  logic        busy_m, done_m, err_m, busy_a, done_a, err_a;
  logic [1:0]  result_m, result_a;
  logic [2:0]  line_m, line_a;
`ifdef JUDGE_LINE_MASK_EN
  logic [8:0]  mask_m, mask_a;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_judge #(.AUTO_START(1'b0)) dut_m (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix),
    .busy(busy_m), .done(done_m), .result(result_m), .win_line(line_m),
`ifdef JUDGE_LINE_MASK_EN
    .win_mask(mask_m),
`endif
    .error(err_m)
  );

  board_judge #(.AUTO_START(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix),
    .busy(busy_a), .done(done_a), .result(result_a), .win_line(line_a),
`ifdef JUDGE_LINE_MASK_EN
    .win_mask(mask_a),
`endif
    .error(err_a)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a board with a start pulse, wait for done on the manual instance, check everything.
  task automatic run_judge(input vec_t v);
    int n;
    int busy_n;
    @(negedge clk);
    matrix = v.m;
    start  = 1'b1;
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy_m) busy_n++;
    end while (!done_m && n < 30);
    chk({v.tag, " latency"}, n, 10);
    chk({v.tag, " busy cycles"}, busy_n, 9);
    chk({v.tag, " result"}, result_m, v.res);
    chk({v.tag, " win_line"}, line_m, v.line);
    chk({v.tag, " error"}, err_m, v.err);
`ifdef JUDGE_LINE_MASK_EN
    chk({v.tag, " win_mask"}, mask_m, v.mask);
`endif
    @(negedge clk);
    chk({v.tag, " done pulse width"}, done_m, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    int m;
    int busy_seen;
    int done_seen;

    vecs[0] = '{18'h00000, 2'b00, 3'd0, 1'b0, 9'h000, "empty"};
    vecs[1] = '{18'h00015, 2'b01, 3'd0, 1'b0, 9'h007, "row0 p1"};
    vecs[2] = '{{X,X,O,O,O,X,X,O,X}, 2'b11, 3'd0, 1'b0, 9'h000, "draw"};
    vecs[3] = '{{O,O,O,E,E,E,X,X,X}, 2'b01, 3'd0, 1'b1, 9'h007, "both players"};
    vecs[4] = '{{E,E,E,E,I,E,E,E,E}, 2'b00, 3'd0, 1'b1, 9'h000, "illegal cell4"};
    vecs[5] = '{18'h3FFFF, 2'b00, 3'd0, 1'b1, 9'h000, "all illegal"};
    vecs[6] = '{{E,O,E,E,O,E,E,O,E}, 2'b10, 3'd4, 1'b0, 9'h092, "col1 p2"};
    vecs[7] = '{{X,X,O,O,X,O,X,O,X}, 2'b01, 3'd6, 1'b0, 9'h111, "full board diag"};
    vecs[8] = '{{E,E,X,X,X,X,E,E,X}, 2'b01, 3'd1, 1'b0, 9'h038, "two p1 lines"};
    vecs[9] = '{{X,E,O,X,E,O,X,E,O}, 2'b10, 3'd3, 1'b1, 9'h049, "p2 first then p1"};

    rst = 1'b1;
    start = 1'b0;
    matrix = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy_m, 0);
    chk("reset done", done_m, 0);
    chk("reset result", result_m, 0);
    chk("reset win_line", line_m, 0);
    chk("reset error", err_m, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("auto idle on equal board", busy_a, 0);

    for (int i = 0; i < 10; i++) run_judge(vecs[i]);

    // Anti-diagonal P2; mid-scan board change and start must not disturb the judgement.
    @(negedge clk);
    matrix = {E,E,O,E,O,E,O,E,E};
    start  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 4) begin
        matrix = '0;
        start  = 1'b1;
      end
    end while (!done_m && n < 30);
    chk("antidiag latency", n, 10);
    chk("antidiag result", result_m, 2'b10);
    chk("antidiag win_line", line_m, 3'd7);
    chk("antidiag error", err_m, 0);
    chk("antidiag auto done", done_a, 1);
    chk("antidiag auto result", result_a, 2'b10);
    // Auto instance re-judges the changed board back-to-back; manual one stays idle.
    m = 0;
    busy_seen = 0;
    do begin
      @(negedge clk);
      m++;
      if (busy_m) busy_seen++;
    end while (!done_a && m < 30);
    chk("rejudge latency", m, 10);
    chk("rejudge result", result_a, 2'b00);
    chk("rejudge win_line", line_a, 3'd0);
    chk("manual stays idle", busy_seen, 0);

    // Reset in the middle of a scan aborts it.
    @(negedge clk);
    matrix = 18'h00015;
    start  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", busy_m, 0);
    chk("abort done", done_m, 0);
    chk("abort result", result_m, 0);
    chk("abort win_line", line_m, 0);
    chk("abort error", err_m, 0);
`ifdef JUDGE_LINE_MASK_EN
    chk("abort win_mask", mask_m, 0);
`endif
    rst = 1'b0;
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_m) done_seen++;
    end
    chk("no done after abort", done_seen, 0);
    run_judge('{18'h00015, 2'b01, 3'd0, 1'b0, 9'h007, "after abort"});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
